// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first,
// repeated reps times with gap zero bits between repetitions, then pulses done.
module pattern_tx #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       reps,
    input  logic [1:0]       gap,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);
    localparam int IW = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IW-1:0] TOP = IW'(PAT_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} state_t;

    state_t           state, state_n;
    logic [PAT_W-1:0] pat_q, pat_n;
    logic [IW-1:0]    idx, idx_n;
    logic [3:0]       rep_cnt, rep_n;
    logic [1:0]       gap_q, gap_qn;
    logic [1:0]       gap_cnt, gap_cnt_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pat_q   <= '0;
            idx     <= '0;
            rep_cnt <= '0;
            gap_q   <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_n;
            pat_q   <= pat_n;
            idx     <= idx_n;
            rep_cnt <= rep_n;
            gap_q   <= gap_qn;
            gap_cnt <= gap_cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        pat_n     = pat_q;
        idx_n     = idx;
        rep_n     = rep_cnt;
        gap_qn    = gap_q;
        gap_cnt_n = gap_cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    if (reps != 4'd0) begin
                        state_n = SEND;
                        pat_n   = pattern;
                        rep_n   = reps;
                        gap_qn  = gap;
                        idx_n   = TOP;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SEND: begin
                if (idx == '0) begin
                    rep_n = rep_cnt - 4'd1;
                    if (rep_cnt == 4'd1) begin
                        state_n = DONE;
                    end else if (gap_q == 2'd0) begin
                        // back-to-back repetition keeps the bit stream contiguous
                        idx_n = TOP;
                    end else begin
                        state_n   = GAP;
                        gap_cnt_n = gap_q;
                    end
                end else begin
                    idx_n = idx - 1'b1;
                end
            end
            GAP: begin
                gap_cnt_n = gap_cnt - 2'd1;
                if (gap_cnt == 2'd1) begin
                    state_n = SEND;
                    idx_n   = TOP;
                end
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Moore outputs: decoded from registered state only, so out is 0 whenever valid is 0
    assign valid = (state == SEND);
    assign out   = valid & pat_q[idx];
    assign busy  = (state == SEND) || (state == GAP);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: per-cycle vector table plus a long
// repetition sequence counted against closed-form totals.
module tb_pattern_tx;
    logic       clk = 1'b0;
    logic       rst, start;
    logic [3:0] pattern, reps;
    logic [1:0] gap;
    logic       out, valid, busy, done;

    int checks   = 0;
    int failures = 0;

    pattern_tx #(.PAT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
        .gap(gap), .out(out), .valid(valid), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // inputs applied before an edge, expected outputs just after it
    typedef struct packed {
        logic       r, s;
        logic [3:0] p, rp;
        logic [1:0] g;
        logic       eo, ev, eb, ed;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(logic r, logic s, logic [3:0] p, logic [3:0] rp, logic [1:0] g,
                                logic eo, logic ev, logic eb, logic ed);
        vec_t v;
        v.r = r; v.s = s; v.p = p; v.rp = rp; v.g = g;
        v.eo = eo; v.ev = ev; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endfunction

    // start-less row; pattern/reps/gap deliberately scrambled to prove they are latched
    function automatic void nxt(logic eo, logic ev, logic eb, logic ed);
        add(1'b0, 1'b0, 4'h0, 4'h0, 2'd0, eo, ev, eb, ed);
    endfunction

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", nm, act, exp_v);
        end
    endtask

    int bcnt, vcnt, ones;
    bit seen;

    initial begin
        // reset and idle
        add(1, 0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0);
        nxt(0, 0, 0, 0);
        // reps=1 gap=0: 1011 then done
        add(0, 1, 4'b1011, 4'd1, 2'd0, 1, 1, 1, 0);
        nxt(0, 1, 1, 0); nxt(1, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(0, 0, 0, 1); nxt(0, 0, 0, 0);
        // reps=3 gap=0: contiguous 101110111011
        add(0, 1, 4'b1011, 4'd3, 2'd0, 1, 1, 1, 0);
        nxt(0, 1, 1, 0); nxt(1, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(1, 1, 1, 0); nxt(0, 1, 1, 0); nxt(1, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(1, 1, 1, 0); nxt(0, 1, 1, 0); nxt(1, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(0, 0, 0, 1); nxt(0, 0, 0, 0);
        // reps=2 gap=2: 1011 00 1011
        add(0, 1, 4'b1011, 4'd2, 2'd2, 1, 1, 1, 0);
        nxt(0, 1, 1, 0); nxt(1, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(0, 0, 1, 0); nxt(0, 0, 1, 0);
        nxt(1, 1, 1, 0); nxt(0, 1, 1, 0); nxt(1, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(0, 0, 0, 1); nxt(0, 0, 0, 0);
        // reps=2 gap=1: 1001 0 1001
        add(0, 1, 4'b1001, 4'd2, 2'd1, 1, 1, 1, 0);
        nxt(0, 1, 1, 0); nxt(0, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(0, 0, 1, 0);
        nxt(1, 1, 1, 0); nxt(0, 1, 1, 0); nxt(0, 1, 1, 0); nxt(1, 1, 1, 0);
        nxt(0, 0, 0, 1); nxt(0, 0, 0, 0);
        // reps=0: immediate done, nothing sent
        add(0, 1, 4'b1111, 4'd0, 2'd3, 0, 0, 0, 1);
        nxt(0, 0, 0, 0);
        // restart attempts in SEND and DONE are ignored
        add(0, 1, 4'b1011, 4'd1, 2'd0, 1, 1, 1, 0);
        add(0, 1, 4'b0110, 4'd5, 2'd3, 0, 1, 1, 0);
        add(0, 1, 4'b0110, 4'd5, 2'd3, 1, 1, 1, 0);
        add(0, 1, 4'b0110, 4'd5, 2'd3, 1, 1, 1, 0);
        add(0, 1, 4'b0110, 4'd5, 2'd3, 0, 0, 0, 1);
        add(0, 1, 4'b0110, 4'd5, 2'd3, 0, 0, 0, 0);
        nxt(0, 0, 0, 0);
        // reset during the 3rd bit aborts with no done
        add(0, 1, 4'b1011, 4'd2, 2'd0, 1, 1, 1, 0);
        nxt(0, 1, 1, 0); nxt(1, 1, 1, 0);
        add(1, 0, 4'h0, 4'h0, 2'd0, 0, 0, 0, 0);
        nxt(0, 0, 0, 0); nxt(0, 0, 0, 0);
        // reset overrides a simultaneous start
        add(1, 1, 4'b1111, 4'd3, 2'd0, 0, 0, 0, 0);
        // fresh start after reset
        add(0, 1, 4'b0110, 4'd1, 2'd0, 0, 1, 1, 0);
        nxt(1, 1, 1, 0); nxt(1, 1, 1, 0); nxt(0, 1, 1, 0);
        nxt(0, 0, 0, 1); nxt(0, 0, 0, 0);

        rst = 1'b1; start = 1'b0; pattern = '0; reps = '0; gap = '0;
        @(posedge clk); #1;

        foreach (vecs[i]) begin
            rst = vecs[i].r; start = vecs[i].s; pattern = vecs[i].p;
            reps = vecs[i].rp; gap = vecs[i].g;
            @(posedge clk); #1;
            chk($sformatf("row%0d.out", i),   out,   vecs[i].eo);
            chk($sformatf("row%0d.valid", i), valid, vecs[i].ev);
            chk($sformatf("row%0d.busy", i),  busy,  vecs[i].eb);
            chk($sformatf("row%0d.done", i),  done,  vecs[i].ed);
        end

        // reps=15 gap=3 pattern=1000: 60 bits, 42 gap cycles, 15 ones
        rst = 0; start = 1; pattern = 4'b1000; reps = 4'd15; gap = 2'd3;
        @(posedge clk); #1;
        start = 0; pattern = 4'b0111; reps = 4'd1; gap = 2'd0;
        bcnt = 0; vcnt = 0; ones = 0; seen = 0;
        for (int c = 0; c < 300 && !seen; c++) begin
            if (done) seen = 1;
            else begin
                bcnt += int'(busy); vcnt += int'(valid); ones += int'(out);
                @(posedge clk); #1;
            end
        end
        chk("long.done_seen", int'(seen), 1);
        chk("long.busy_cycles", bcnt, 102);
        chk("long.valid_cycles", vcnt, 60);
        chk("long.ones", ones, 15);
        @(posedge clk); #1;
        chk("long.done_single", int'(done), 0);
        chk("long.idle_busy", int'(busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
